input_capture_module: RTL and testbench
=======================================

INPUT_CAPTURE_MODULE -- requirements
Module: Input_Capture_Module

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, meaning clk frequency in Hz and the dividend of the frequency computation.
REQ-002 Parameter TIMEOUT_CYCLES, default 100_000_000, meaning the number of cycles without an input edge before frequency is forced to 0.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port signal_in, input, 1 bit: asynchronous square-wave input to be measured.
REQ-006 Port frequency, output, 32 bits: last measured input frequency in Hz, unsigned, registered.
REQ-007 Port measurement_done, output, 1 bit: registered one-cycle pulse, high in the same cycle frequency takes a new value.

Function
REQ-008 signal_in SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected when the synchronized value is 1 and its previous registered value was 0.
REQ-009 Latency from a signal_in rising transition to edge detection SHALL be 3 clk cycles; falling edges SHALL be ignored.
REQ-010 The FSM SHALL have three states: ARM, COUNT and DIVIDE; the reset state is ARM.
REQ-011 In ARM, the first detected rising edge SHALL clear the period counter, enter COUNT and produce no measurement.
REQ-012 In COUNT, the 32-bit period counter SHALL increment every cycle; on the next rising edge, P = cycles elapsed since the previous edge SHALL be latched, the counter SHALL restart, and the FSM SHALL enter DIVIDE.
REQ-013 DIVIDE SHALL compute floor(CLK_FREQ / P) with a restoring divider, 1 quotient bit per cycle, 32 iterations.
REQ-014 In the cycle after the last iteration, frequency SHALL be loaded with the quotient, measurement_done SHALL pulse for exactly 1 cycle, and the FSM SHALL return to COUNT.
REQ-015 The period counter SHALL keep counting during DIVIDE.
REQ-016 A rising edge detected during DIVIDE SHALL restart the counter, but its period SHALL be discarded (no queued measurement).
REQ-017 The minimum measurable P is 2 cycles (25 MHz at the default CLK_FREQ); divide-by-zero cannot occur.
REQ-018 If the period counter reaches TIMEOUT_CYCLES in COUNT, then frequency SHALL be set to 0, measurement_done SHALL pulse once, and the FSM SHALL return to ARM.
REQ-019 While in ARM after a timeout, no further done pulses SHALL occur.
REQ-020 The period counter SHALL saturate and never wrap.
REQ-021 Between updates, frequency SHALL hold its value.
REQ-022 measurement_done SHALL never be high in two consecutive cycles.

Reset
REQ-023 While rst=1 at a clk edge: frequency=0, measurement_done=0, FSM=ARM, period counter=0, divider state cleared, synchronizer flops=0.
REQ-024 Reset asserted mid-COUNT or mid-DIVIDE SHALL abort the measurement with no done pulse, and frequency SHALL read 0 from the next cycle.
REQ-025 After reset is released, the first rising edge only arms (REQ-011); the first valid result follows the second rising edge.

Verification
REQ-026 Toggle signal_in every 50 ms (10 Hz, P = 5,000,000 cycles) -> no done pulse at the 1st rising edge; after the 2nd rising edge plus about 36 cycles, frequency = 10 with a single done pulse; the same result repeats every 100 ms.
REQ-027 Drive 1 kHz (P = 50,000) -> frequency = 1000; then switch to 0.5 Hz (P = 100,000,000, which hits the timeout first) -> frequency = 0 with one done pulse, and no further pulses.
REQ-028 Drive P = 3 cycles -> frequency = 16,666,666 (floor); the intermediate edges during DIVIDE are discarded, and every done pulse shows 16,666,666.
REQ-029 Drive P = 2 cycles (25 MHz) -> frequency = 25,000,000.
REQ-030 Assert rst for 1 cycle during DIVIDE -> no done pulse, and frequency = 0 the next cycle; the following measurement requires two fresh rising edges.
REQ-031 Hold signal_in constant for 2 s after reset -> frequency stays 0 and measurement_done never pulses.

Source files
------------

// File: rtl/input_capture_module.sv
// Input capture: measures the period of a square wave between synchronized
// rising edges and converts it to Hz with a 32-step restoring divider.
module input_capture_module #(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        signal_in,
  output logic [31:0] frequency,
  output logic        measurement_done
);

  typedef enum logic [1:0] {
    ARM    = 2'd0,
    COUNT  = 2'd1,
    DIVIDE = 2'd2
  } state_t;

  localparam logic [31:0] DIVIDEND  = 32'(CLK_FREQ);
  localparam logic [31:0] TIMEOUT   = 32'(TIMEOUT_CYCLES);
  localparam logic [5:0]  LAST_ITER = 6'd32;

  logic        sync1_r;
  logic        sync2_r;
  logic        prev_r;
  state_t      state_r;
  state_t      state_s;
  logic [31:0] cnt_r;
  logic [31:0] cnt_s;
  logic [31:0] cnt_inc_s;
  logic [31:0] divisor_r;
  logic [31:0] divisor_s;
  logic [31:0] rem_r;
  logic [31:0] rem_s;
  logic [31:0] quo_r;
  logic [31:0] quo_s;
  logic [31:0] freq_s;
  logic [5:0]  iter_r;
  logic [5:0]  iter_s;
  logic        done_s;
  logic        rise_s;
  logic        timeout_s;
  logic        sub_ok_s;
  logic [32:0] rem_shift_s;
  logic [31:0] diff_s;

  // Two-flop synchronizer plus the previous-value flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= signal_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // The counter holds cycles elapsed since the last edge, so it equals P on the next edge.
  // Timeout is held off right after a result so done can never pulse twice in a row.
  always_comb begin
    rise_s      = sync2_r & ~prev_r;
    cnt_inc_s   = (cnt_r == 32'hFFFF_FFFF) ? cnt_r : (cnt_r + 32'd1);
    timeout_s   = (cnt_r >= TIMEOUT) & ~measurement_done;
    rem_shift_s = {rem_r, quo_r[31]};
    sub_ok_s    = (rem_shift_s >= {1'b0, divisor_r});
    diff_s      = rem_shift_s[31:0] - divisor_r;
  end

  // Next-state and datapath control
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    divisor_s = divisor_r;
    rem_s     = rem_r;
    quo_s     = quo_r;
    iter_s    = iter_r;
    freq_s    = frequency;
    done_s    = 1'b0;
    case (state_r)
      ARM: begin
        if (rise_s) begin
          cnt_s   = 32'd1;
          state_s = COUNT;
        end else begin
          cnt_s   = cnt_r;
          state_s = ARM;
        end
      end
      COUNT: begin
        if (timeout_s) begin
          freq_s  = 32'd0;
          done_s  = 1'b1;
          cnt_s   = 32'd0;
          state_s = ARM;
        end else if (rise_s) begin
          divisor_s = cnt_r;
          rem_s     = 32'd0;
          quo_s     = DIVIDEND;
          iter_s    = 6'd0;
          cnt_s     = 32'd1;
          state_s   = DIVIDE;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      DIVIDE: begin
        if (rise_s) begin
          cnt_s = 32'd1;
        end else begin
          cnt_s = cnt_inc_s;
        end
        if (iter_r == LAST_ITER) begin
          freq_s  = quo_r;
          done_s  = 1'b1;
          state_s = COUNT;
        end else begin
          rem_s  = sub_ok_s ? diff_s : rem_shift_s[31:0];
          quo_s  = {quo_r[30:0], sub_ok_s};
          iter_s = iter_r + 6'd1;
        end
      end
      default: begin
        state_s = ARM;
        cnt_s   = 32'd0;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ARM;
      cnt_r            <= 32'd0;
      divisor_r        <= 32'd0;
      rem_r            <= 32'd0;
      quo_r            <= 32'd0;
      iter_r           <= 6'd0;
      frequency        <= 32'd0;
      measurement_done <= 1'b0;
    end else begin
      state_r          <= state_s;
      cnt_r            <= cnt_s;
      divisor_r        <= divisor_s;
      rem_r            <= rem_s;
      quo_r            <= quo_s;
      iter_r           <= iter_s;
      frequency        <= freq_s;
      measurement_done <= done_s;
    end
  end

endmodule

// File: tb/tb_input_capture_module.sv
// Bench for input_capture_module: a timestamp-based reference model predicts
// frequency/measurement_done every cycle; literal checks pin key results.
module tb_input_capture_module;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int          TIMEOUT  = 3000;
  localparam int          DIV_LAT  = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        signal_in;
  logic [31:0] frequency;
  logic        measurement_done;

  always #5 clk = ~clk;

  input_capture_module #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .signal_in(signal_in),
    .frequency(frequency),
    .measurement_done(measurement_done)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, actual, expected);
    end
  endtask

  // Reference model: a rising edge is seen by the measurement logic when the
  // input was 1 two samples ago and 0 three samples ago; results appear
  // DIV_LAT cycles after the measuring edge.
  int          cyc = 0;
  int          last_edge = 0;
  int          busy_end = 0;
  int          mode = 0;          // 0 armed, 1 counting, 2 busy dividing
  logic [31:0] pend = 32'd0;
  logic [31:0] exp_freq = 32'd0;
  logic        exp_done = 1'b0;
  logic        a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;

  always @(posedge clk) begin
    int  elapsed;
    bit  rise;
    cyc++;
    if (rst) begin
      mode = 0; exp_freq = 32'd0; exp_done = 1'b0;
      a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
    end else begin
      rise     = a2 && !a3;
      elapsed  = cyc - last_edge;
      exp_done = 1'b0;
      case (mode)
        0: if (rise) begin mode = 1; last_edge = cyc; end
        1: begin
          if (elapsed >= TIMEOUT) begin
            exp_freq = 32'd0; exp_done = 1'b1; mode = 0;
          end else if (rise) begin
            pend = 32'(CLK_FREQ / elapsed);
            busy_end = cyc + DIV_LAT;
            last_edge = cyc;
            mode = 2;
          end
        end
        default: begin
          if (rise) last_edge = cyc;
          if (cyc == busy_end) begin
            exp_freq = pend; exp_done = 1'b1; mode = 1;
          end
        end
      endcase
      a3 = a2; a2 = a1; a1 = signal_in;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always begin
    @(posedge clk);
    #2;
    check("freq", frequency, exp_freq);
    check("done", {31'd0, measurement_done}, {31'd0, exp_done});
    check("done_b2b", {31'd0, measurement_done & done_prev}, 32'd0);
    if (measurement_done === 1'b1) done_cnt++;
    done_prev = measurement_done;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sq(input int hi, input int lo);
    signal_in = 1'b1; cycles(hi);
    signal_in = 1'b0; cycles(lo);
  endtask

  initial begin
    int base;
    rst = 1'b1; signal_in = 1'b0;
    cycles(3);
    rst = 1'b0;
    check("reset_freq", frequency, 32'd0);
    check("reset_done", {31'd0, measurement_done}, 32'd0);

    // Constant input: no measurement, no timeout while armed
    base = done_cnt;
    cycles(4000);
    check("idle_no_done", 32'(done_cnt - base), 32'd0);
    check("idle_freq", frequency, 32'd0);

    // P = 3 with edges landing during DIVIDE
    repeat (100) sq(2, 1);
    check("p3_freq", frequency, 32'd16666666);
    check("p3_model", exp_freq, 32'd16666666);

    // P = 2, fastest measurable input
    repeat (150) sq(1, 1);
    check("p2_freq", frequency, 32'd25000000);

    // P = 1000
    repeat (4) sq(500, 500);
    check("p1000_freq", frequency, 32'd50000);

    // Reset in the middle of DIVIDE
    signal_in = 1'b1;
    cycles(18);
    rst = 1'b1; signal_in = 1'b0;
    cycles(1);
    rst = 1'b0;
    check("rst_div_freq", frequency, 32'd0);
    base = done_cnt;
    cycles(60);
    check("rst_div_no_done", 32'(done_cnt - base), 32'd0);

    // First fresh edge only arms, second measures
    base = done_cnt;
    sq(500, 500);
    check("rearm_no_done", 32'(done_cnt - base), 32'd0);
    check("rearm_freq", frequency, 32'd0);
    sq(500, 500);
    check("remeasure_freq", frequency, 32'd50000);

    // Timeout: one zero result, then silence while armed
    base = done_cnt;
    cycles(3500);
    check("timeout_freq", frequency, 32'd0);
    check("timeout_one_pulse", 32'(done_cnt - base), 32'd1);
    base = done_cnt;
    cycles(1000);
    check("armed_quiet", 32'(done_cnt - base), 32'd0);

    // Random duty/period mix
    repeat (40) sq(int'($urandom_range(1, 600)), int'($urandom_range(1, 600)));
    cycles(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
